uart_rx_core: RTL and testbench

- Synthesizable UART receiver. It deserializes the line driven by the UART tx agent into parallel bytes.
- Sits as the DUT on the uart_if serial line in the UART environment. The rx agent side observes its output handshake.
- Fixed format: 1 start bit, DATA_WIDTH data bits (LSB first), optional parity, 1 stop bit. Bit timing is derived from pclk by an integer divider.

---
 rtl/uart_rx_core.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver core: 2-flop synchronizer, bit-timing FSM, holding register; optional parity via UART_RX_PARITY_EN
module uart_rx_core #(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam logic [15:0] LP_HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] LP_FULL = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LP_LAST = 4'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
  localparam bit LP_PARITY_EN = 1'b1;
`else
  localparam bit LP_PARITY_EN = 1'b0;
`endif

  state_t                r_state;
  state_t                w_state_n;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic                  r_rx_prev;
  logic [15:0]           r_cnt;
  logic [3:0]            r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;

  logic w_expire;
  logic w_load_half;
  logic w_load_full;
  logic w_idx_clr;
  logic w_shift_en;
  logic w_par_en;
  logic w_stop_good;
  logic w_stop_bad;
  logic w_par_bad;
  logic w_par_fail;
  logic w_frame_ok;
  logic w_consume;

  assign w_expire   = (r_cnt == 16'd0);
  assign w_par_bad  = ((^r_shift) ^ PARITY_ODD) != r_par_bit;
  assign w_par_fail = LP_PARITY_EN && w_par_bad;
  assign w_frame_ok = w_stop_good && !w_par_fail;
  assign w_consume  = rx_valid && rx_ready;
  assign busy       = (r_state != S_IDLE);

  // Bring the asynchronous line into pclk and keep one cycle of history for edge detection
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic and per-state datapath strobes
  always_comb begin
    w_state_n   = r_state;
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_idx_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_state_n   = S_START;
          w_load_half = 1'b1;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (r_rx_s) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n   = S_DATA;
            w_load_full = 1'b1;
            w_idx_clr   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_idx == LP_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (w_expire) begin
          w_par_en    = 1'b1;
          w_load_full = 1'b1;
          w_state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          if (r_rx_s) begin
            w_stop_good = 1'b1;
            w_state_n   = S_IDLE;
          end else begin
            w_stop_bad = 1'b1;
            w_state_n  = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Bit-period down-counter, bit index and LSB-first shift register
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_cnt     <= 16'd0;
      r_bit_idx <= 4'd0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if (w_load_half) begin
        r_cnt <= LP_HALF;
      end else if (w_load_full) begin
        r_cnt <= LP_FULL;
      end else if (!w_expire) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_idx_clr) begin
        r_bit_idx <= 4'd0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 4'd1;
      end
      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
      end
      if (w_par_en) begin
        r_par_bit <= r_rx_s;
      end
    end
  end

  // Holding register, handshake and one-cycle error pulses; a consume in the load cycle frees the slot
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_stop_bad;
      parity_err  <= w_stop_good && w_par_fail;
      overrun_err <= 1'b0;
      if (w_frame_ok && (!rx_valid || w_consume)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else begin
        if (w_frame_ok) begin
          overrun_err <= 1'b1;
        end
        if (w_consume) begin
          rx_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - table-driven self-checking bench for uart_rx_core
module tb_uart_rx_core;

  localparam int BAUD = 16;
  localparam int DW   = 8;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + BAUD / 2 + (DW + 1 + (PAR_EN ? 1 : 0)) * BAUD + 1;

  logic          pclk = 1'b0;
  logic          areset;
  logic          rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;

  uart_rx_core #(.BAUD_DIV(BAUD), .DATA_WIDTH(DW), .PARITY_ODD(PODD)) dut (
    .pclk        (pclk),
    .areset      (areset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 pclk = ~pclk;

  // event counters sampled on the falling edge
  int       n_hs = 0;
  int       n_fe = 0;
  int       n_pe = 0;
  int       n_ov = 0;
  logic [7:0] last_data = 8'h00;

  always @(negedge pclk) begin
    if (rx_valid && rx_ready) begin
      n_hs      <= n_hs + 1;
      last_data <= rx_data;
    end
    if (frame_err)   n_fe <= n_fe + 1;
    if (parity_err)  n_pe <= n_pe + 1;
    if (overrun_err) n_ov <= n_ov + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int s_hs, s_fe, s_pe, s_ov;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_deliv;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_hs = n_hs;
    s_fe = n_fe;
    s_pe = n_pe;
    s_ov = n_ov;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD) @(posedge pclk);
    #1;
  endtask

  // caller is at posedge+1; line returns high after the stop bit (plus optional low tail)
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop, input int tail_low);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_of(d) ^ bad_par);
    drive_bit(stop);
    if (tail_low > 0) begin
      rx = 1'b0;
      repeat (tail_low) @(posedge pclk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 1, 0};

    areset   = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge pclk);
    check("reset_outs", {rx_data, rx_valid, busy, frame_err, parity_err, overrun_err}, 0);
    @(posedge pclk);
    #1 areset = 1'b0;
    idle(4);

    // latency and single-cycle valid for 0xA5
    snap();
    lat = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      begin
        while (lat < 400) begin
          @(posedge pclk);
          lat++;
          @(negedge pclk);
          if (rx_valid) break;
        end
        check("lat_data", rx_data, 8'hA5);
        @(negedge pclk);
        check("lat_valid_1cyc", rx_valid, 0);
      end
    join
    check("lat_cycles", lat, LAT);
    idle(BAUD);
    check("lat_errs", (n_fe - s_fe) + (n_pe - s_pe) + (n_ov - s_ov), 0);

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      snap();
      send_frame(vecs[v].data, 1'b0, vecs[v].stop, 0);
      idle(2 * BAUD);
      check($sformatf("vec%0d_deliv", v), n_hs - s_hs, vecs[v].exp_deliv);
      check($sformatf("vec%0d_ferr", v), n_fe - s_fe, vecs[v].exp_ferr);
      check($sformatf("vec%0d_perr", v), n_pe - s_pe, 0);
      check($sformatf("vec%0d_ovr", v), n_ov - s_ov, 0);
      if (vecs[v].exp_deliv != 0) check($sformatf("vec%0d_data", v), last_data, vecs[v].data);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // glitch: 4-cycle low pulse is a false start
    snap();
    rx = 1'b0;
    repeat (4) @(posedge pclk);
    #1 rx = 1'b1;
    @(negedge pclk);
    check("glitch_busy_seen", busy, 1);
    cyc = 0;
    while (busy && cyc < 11) begin
      @(negedge pclk);
      cyc++;
    end
    check("glitch_busy_clear", busy, 0);
    idle(2 * BAUD);
    check("glitch_no_deliv", n_hs - s_hs, 0);
    check("glitch_no_err", (n_fe - s_fe) + (n_pe - s_pe) + (n_ov - s_ov), 0);

    // bad stop then 40-cycle break, then a good frame
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 40);
    idle(2 * BAUD);
    send_frame(8'h11, 1'b0, 1'b1, 0);
    idle(2 * BAUD);
    check("brk_ferr_once", n_fe - s_fe, 1);
    check("brk_deliv", n_hs - s_hs, 1);
    check("brk_data", last_data, 8'h11);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h01, 1'b0, 1'b1, 0);
    idle(2 * BAUD);
    send_frame(8'h02, 1'b0, 1'b1, 0);
    idle(2 * BAUD);
    check("ovr_pulse", n_ov - s_ov, 1);
    check("ovr_keep_data", rx_data, 8'h01);
    check("ovr_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge pclk);
    #1 rx_ready = 1'b0;
    @(negedge pclk);
    check("ovr_drain_valid", rx_valid, 0);
    check("ovr_drain_hs", n_hs - s_hs, 1);
    rx_ready = 1'b1;
    idle(2);

`ifdef UART_RX_PARITY_EN
    // wrong parity then correct parity for 0x07
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(2 * BAUD);
    check("par_err_pulse", n_pe - s_pe, 1);
    check("par_err_nodeliv", n_hs - s_hs, 0);
    send_frame(8'h07, 1'b0, 1'b1, 0);
    idle(2 * BAUD);
    check("par_ok_deliv", n_hs - s_hs, 1);
    check("par_ok_data", last_data, 8'h07);
    check("par_ok_pe", n_pe - s_pe, 1);
`endif

    // reset during data bit 4 of 0xFF, then a clean 0x5A
    snap();
    fork
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      begin
        repeat (88) @(posedge pclk);
        #1 areset = 1'b1;
        @(negedge pclk);
        check("rst_mid_outs", {rx_data, rx_valid, busy, frame_err, parity_err, overrun_err}, 0);
        repeat (3) @(posedge pclk);
        #1 areset = 1'b0;
      end
    join
    idle(2 * BAUD);
    check("rst_no_deliv", n_hs - s_hs, 0);
    check("rst_no_err", (n_fe - s_fe) + (n_pe - s_pe) + (n_ov - s_ov), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    idle(2 * BAUD);
    check("rst_after_deliv", n_hs - s_hs, 1);
    check("rst_after_data", last_data, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
